// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence checker and generator-side code.
package lfsr_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_IDX_W = 6;

  // One generator step on the low 'width' bits: shift right, MSB <= MSB ^ LSB.
  function automatic logic [MAX_W-1:0] next(input logic [MAX_W-1:0] x,
                                            input int unsigned     width);
    logic [MAX_W-1:0] r;
    r = x >> 1;
    r[MAX_IDX_W'(width - 1)] = x[MAX_IDX_W'(width - 1)] ^ x[0];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational WIDTH-bit LFSR next-step, shared with the generator side.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] nxt_c
);

  assign nxt_c = WIDTH'(next(MAX_W'(cur_i), WIDTH));

endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR sequence checker: searches for lock, then flywheels and counts mismatches.
// Optional error counter enabled with macro LFSR_CHK_ERRCNT_EN.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOST_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_vld,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOST_CNT + 1);

  state_e             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic               seed_q, seed_d;
  logic               err_q, err_d;
  logic               locked_q;
  logic [WIDTH-1:0]   nxt;
  logic               hit;

  // ref_q holds the last word (SEARCH) or the last expected word (LOCKED);
  // in both states the word to compare against is next(ref_q).
  lfsr_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur_i (ref_q),
    .nxt_c (nxt)
  );

  assign hit = (data_in == nxt);

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    ref_d   = ref_q;
    seed_d  = seed_q;
    err_d   = 1'b0;
    if (data_vld) begin
      unique case (state_q)
        SEARCH: begin
          ref_d = data_in;
          if (data_in == '0) begin
            match_d = '0;
            seed_d  = 1'b0;
          end else if (!seed_q) begin
            seed_d = 1'b1;
          end else if (hit) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          ref_d = nxt;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (miss_q == MISS_W'(LOST_CNT - 1)) begin
              state_d = SEARCH;
              miss_d  = '0;
              match_d = '0;
              seed_d  = 1'b0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      match_q  <= '0;
      miss_q   <= '0;
      ref_q    <= '0;
      seed_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      ref_q    <= ref_d;
      seed_q   <= seed_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

`ifdef LFSR_CHK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count; clear wins over a simultaneous increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_cnt        = '0;
`endif

endmodule
